// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution, misalign detection and forwarding port.
// A taken branch requests redirect once; `fired` suppresses repeats while the stage is stalled.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic        ex_zero,
  input  logic [31:0] ex_write_data,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_branch_eq,
  input  logic        ex_branch_ne,
  output logic        mem_valid,
  output logic [31:0] mem_result,
  output logic [31:0] mem_write_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_mem_to_reg,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        misalign_fault,
  output logic [7:0]  fault_count,
  output logic        fwd_en,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);
  logic branch_eq, branch_ne, zero, fired, mis;
  assign mis = ex_valid & (ex_mem_read | ex_mem_write) & (ex_result[1:0] != 2'b00);
  assign branch_taken = mem_valid & ((branch_eq & zero) | (branch_ne & ~zero)) & ~fired;
  assign fwd_en = mem_valid & mem_reg_write & (mem_rd != 5'd0);
  assign fwd_rd = mem_rd;
  assign fwd_data = mem_result;
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      mem_valid      <= 1'b0;
      mem_result     <= 32'd0;
      mem_write_data <= 32'd0;
      mem_rd         <= 5'd0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      branch_target  <= 32'd0;
      branch_eq      <= 1'b0;
      branch_ne      <= 1'b0;
      zero           <= 1'b0;
      misalign_fault <= 1'b0;
      fired          <= 1'b0;
      if (!rst_n) fault_count <= 8'd0;
    end else if (stall) begin
      fired <= fired | branch_taken;
    end else begin
      mem_valid      <= ex_valid;
      mem_result     <= ex_result;
      mem_write_data <= ex_write_data;
      mem_rd         <= ex_rd;
      mem_reg_write  <= ex_valid & ex_reg_write & ~mis;
      mem_mem_read   <= ex_valid & ex_mem_read & ~mis;
      mem_mem_write  <= ex_valid & ex_mem_write & ~mis;
      mem_mem_to_reg <= ex_valid & ex_mem_to_reg;
      branch_target  <= ex_branch_target;
      branch_eq      <= ex_valid & ex_branch_eq;
      branch_ne      <= ex_valid & ex_branch_ne;
      zero           <= ex_zero;
      misalign_fault <= mis;
      fault_count    <= (mis && fault_count != 8'hff) ? fault_count + 8'd1 : fault_count;
      fired          <= 1'b0;
    end
endmodule
